ahb_arbiter_slave: RTL and testbench

Per-slave AHB arbiter that shares one slave port among `CHANNEL_NUM` masters. It produces the one-hot address-phase select consumed by the slave's request multiplexer and the one-hot data-phase select used for the write-data and response paths. It stalls masters that are not granted, and holds ownership across fixed-length bursts and locked sequences. One instance sits beside each slave's mux in the interconnect.

---
 rtl/ahb_arbiter_slave.sv | 143 ++++++++++++++
 tb/tb_ahb_arbiter_slave.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_slave.sv
// Per-slave AHB arbiter: address/data-phase owner selects, master stalls, burst and lock hold.
// Define ARB_RR_EN for round-robin priority; otherwise fixed priority (lowest index wins).
module ahb_arbiter_slave #(
   parameter int unsigned CHANNEL_NUM = 2
) (
   input  logic                           hclk,
   input  logic                           hreset,
   input  logic [CHANNEL_NUM-1:0]         hreq,
   input  logic [2*CHANNEL_NUM-1:0]       htrans,
   input  logic [3*CHANNEL_NUM-1:0]       hburst,
   input  logic [CHANNEL_NUM-1:0]         hmastlock,
   input  logic                           hreadyout,
   output logic [CHANNEL_NUM-1:0]         addr_sel,
   output logic [CHANNEL_NUM-1:0]         data_sel,
   output logic [CHANNEL_NUM-1:0]         hready_m,
   output logic [$clog2(CHANNEL_NUM)-1:0] owner_idx
);
   localparam int unsigned IW  = $clog2(CHANNEL_NUM);
   localparam int unsigned IW1 = IW + 1;
   localparam int unsigned BW  = 4;
   localparam logic [1:0]  TR_IDLE   = 2'd0;
   localparam logic [1:0]  TR_NONSEQ = 2'd2;
   localparam logic [1:0]  TR_SEQ    = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_BURST, ST_LOCK} state_t;

   state_t                 state;
   logic [BW-1:0]          beat_cnt;
   logic [1:0]             trans_a [CHANNEL_NUM];
   logic [2:0]             burst_a [CHANNEL_NUM];
   logic [1:0]             own_trans;
   logic [2:0]             own_burst;
   logic                   own_req;
   logic                   own_active;
   logic                   own_lock;
   logic                   last_beat;
   logic                   arb_open;
   logic [BW-1:0]          burst_len;
   logic [CHANNEL_NUM-1:0] others;
   logic [CHANNEL_NUM-1:0] cand;
   logic [CHANNEL_NUM-1:0] win_oh;
   logic [IW-1:0]          win_idx;
   logic                   win_any;
`ifdef ARB_RR_EN
   logic [IW-1:0]          ptr;
   logic [IW1-1:0]         rr_sum;
   logic                   found;
`endif

   for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_unpack
      assign trans_a[i] = htrans[2*i +: 2];
      assign burst_a[i] = hburst[3*i +: 3];
   end

   // Current owner's transfer and whether this edge may re-arbitrate
   always_comb begin
      own_trans  = trans_a[owner_idx];
      own_burst  = burst_a[owner_idx];
      own_req    = (|addr_sel) & hreq[owner_idx];
      own_active = own_req & own_trans[1];
      own_lock   = own_active & hmastlock[owner_idx];
      last_beat  = (state == ST_BURST) && own_req && (own_trans == TR_SEQ) && (beat_cnt <= BW'(1));
      case (own_burst)
         3'd2, 3'd3: burst_len = BW'(3);
         3'd4, 3'd5: burst_len = BW'(7);
         3'd6, 3'd7: burst_len = BW'(15);
         default:    burst_len = '0;
      endcase
      case (state)
         ST_BURST: arb_open = !own_req || (own_trans == TR_IDLE) || (own_trans == TR_NONSEQ) || last_beat;
         ST_LOCK:  arb_open = !own_req || (own_active && !hmastlock[owner_idx]);
         default:  arb_open = 1'b1;
      endcase
   end

   // Winner select; a finishing burst owner yields to any other requester
   always_comb begin
      others  = hreq & ~addr_sel;
      cand    = (last_beat && (|others)) ? others : hreq;
      win_any = |cand;
      win_idx = '0;
`ifdef ARB_RR_EN
      rr_sum  = '0;
      found   = 1'b0;
      for (int k = 0; k < int'(CHANNEL_NUM); k++) begin
         rr_sum = {1'b0, ptr} + IW1'(k);
         if (rr_sum >= IW1'(CHANNEL_NUM)) rr_sum = rr_sum - IW1'(CHANNEL_NUM);
         if (!found && cand[IW'(rr_sum)]) begin
            found   = 1'b1;
            win_idx = IW'(rr_sum);
         end
      end
`else
      for (int k = int'(CHANNEL_NUM) - 1; k >= 0; k--) begin
         if (cand[k]) win_idx = IW'(k);
      end
`endif
      win_oh          = '0;
      win_oh[win_idx] = win_any;
   end

   always_comb begin
      hready_m = '1;
      for (int i = 0; i < int'(CHANNEL_NUM); i++) begin
         hready_m[i] = hreset | ((addr_sel[i] | data_sel[i]) ? hreadyout : !hreq[i]);
      end
   end

   // Ownership FSM; nothing moves while the slave inserts wait states
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state     <= ST_IDLE;
         beat_cnt  <= '0;
         addr_sel  <= '0;
         data_sel  <= '0;
         owner_idx <= '0;
`ifdef ARB_RR_EN
         ptr       <= '0;
`endif
      end else if (hreadyout) begin
         data_sel <= own_active ? addr_sel : '0;
         if (own_lock) begin
            state    <= ST_LOCK;
            beat_cnt <= '0;
         end else if (arb_open) begin
            if (own_req && (own_trans == TR_NONSEQ) && (burst_len != '0)) begin
               state    <= ST_BURST;
               beat_cnt <= burst_len;
            end else begin
               beat_cnt  <= '0;
               addr_sel  <= win_oh;
               owner_idx <= win_idx;
               state     <= win_any ? ST_OWN : ST_IDLE;
`ifdef ARB_RR_EN
               if (win_any) ptr <= (win_idx == IW'(CHANNEL_NUM - 1)) ? '0 : win_idx + IW'(1);
`endif
            end
         end else if ((state == ST_BURST) && (own_trans == TR_SEQ)) begin
            beat_cnt <= beat_cnt - BW'(1);
         end
      end
   end
endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// Directed bench for ahb_arbiter_slave with two masters; honours ARB_RR_EN for contention.
module tb_ahb_arbiter_slave;
   localparam logic [1:0] T_IDLE = 2'd0, T_NS = 2'd2, T_SEQ = 2'd3;
   localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3, B_INCR8 = 3'd5;

   logic       hclk;
   logic       hreset;
   logic [1:0] hreq;
   logic [3:0] htrans;
   logic [5:0] hburst;
   logic [1:0] hmastlock;
   logic       hreadyout;
   logic [1:0] addr_sel;
   logic [1:0] data_sel;
   logic [1:0] hready_m;
   logic [0:0] owner_idx;

   int n_cmp = 0;
   int n_err = 0;
   logic [1:0] exp_a [4];
   logic [1:0] exp_d [4];

   ahb_arbiter_slave #(.CHANNEL_NUM(2)) dut (
      .hclk(hclk), .hreset(hreset), .hreq(hreq), .htrans(htrans), .hburst(hburst),
      .hmastlock(hmastlock), .hreadyout(hreadyout), .addr_sel(addr_sel),
      .data_sel(data_sel), .hready_m(hready_m), .owner_idx(owner_idx)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic set_m(input bit m, input logic rq, input logic [1:0] tr,
                        input logic [2:0] bu, input logic lk);
      hreq[m]                     = rq;
      htrans[{m, 1'b0} +: 2]      = tr;
      hburst[(m ? 3'd3 : 3'd0) +: 3] = bu;
      hmastlock[m]                = lk;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      hreset = 1'b1; hreq = '0; htrans = '0; hburst = '0; hmastlock = '0; hreadyout = 1'b1;
      tick(); tick();
      chk("rst_addr", addr_sel, 2'b00);
      chk("rst_data", data_sel, 2'b00);
      chk("rst_owner", 2'(owner_idx), 2'b00);
      chk("rst_hready", hready_m, 2'b11);
      hreset = 1'b0;

      // single grant
      set_m(0, 1, T_NS, B_SINGLE, 0); #1;
      chk("s1_stall", hready_m, 2'b10);
      tick();
      chk("s1_addr", addr_sel, 2'b01);
      chk("s1_data_idle", data_sel, 2'b00);
      chk("s1_hready", hready_m, 2'b11);
      tick();
      chk("s1_data", data_sel, 2'b01);
      chk("s1_addr_hold", addr_sel, 2'b01);
      set_m(0, 0, T_IDLE, B_SINGLE, 0);
      tick();
      chk("s1_rel_addr", addr_sel, 2'b00);
      chk("s1_rel_data", data_sel, 2'b00);

      // INCR4 burst hold with master 1 waiting
      set_m(0, 1, T_NS, B_INCR4, 0);
      tick();
      chk("b_grant", addr_sel, 2'b01);
      set_m(1, 1, T_NS, B_SINGLE, 0); #1;
      chk("b_beat1_stall", hready_m, 2'b01);
      tick();
      set_m(0, 1, T_SEQ, B_INCR4, 0); #1;
      chk("b_beat2_stall", hready_m, 2'b01);
      chk("b_beat2_addr", addr_sel, 2'b01);
      chk("b_beat2_data", data_sel, 2'b01);
      tick();
      chk("b_beat3_stall", hready_m, 2'b01);
      chk("b_beat3_addr", addr_sel, 2'b01);
      tick();
      chk("b_beat4_stall", hready_m, 2'b01);
      chk("b_beat4_addr", addr_sel, 2'b01);
      tick();
      chk("b_handover_addr", addr_sel, 2'b10);
      chk("b_handover_owner", 2'(owner_idx), 2'b01);
      chk("b_handover_data", data_sel, 2'b01);
      chk("b_handover_hready", hready_m, 2'b11);
      set_m(0, 0, T_IDLE, B_SINGLE, 0);
      tick();
      chk("b_m1_data", data_sel, 2'b10);
      chk("b_m1_addr", addr_sel, 2'b10);
      set_m(1, 0, T_IDLE, B_SINGLE, 0);
      tick();
      chk("b_idle_addr", addr_sel, 2'b00);
      chk("b_idle_data", data_sel, 2'b00);

      // wait states freeze both selects
      set_m(0, 1, T_NS, B_SINGLE, 0);
      tick();
      chk("w_grant", addr_sel, 2'b01);
      tick();
      chk("w_data", data_sel, 2'b01);
      hreadyout = 1'b0;
      set_m(1, 1, T_NS, B_SINGLE, 0); #1;
      for (int i = 0; i < 3; i++) begin
         chk("w_hready", hready_m, 2'b00);
         tick();
         chk("w_addr_frozen", addr_sel, 2'b01);
         chk("w_data_frozen", data_sel, 2'b01);
      end
      hreadyout = 1'b1;
      set_m(0, 0, T_IDLE, B_SINGLE, 0); #1;
      chk("w_resume_hready", hready_m, 2'b01);
      tick();
      chk("w_m1_addr", addr_sel, 2'b10);
      chk("w_m1_owner", 2'(owner_idx), 2'b01);
      chk("w_m1_data_clr", data_sel, 2'b00);
      tick();
      chk("w_m1_data", data_sel, 2'b10);
      set_m(1, 0, T_IDLE, B_SINGLE, 0);
      tick();
      chk("w_idle_addr", addr_sel, 2'b00);

      // locked sequence by master 1
      set_m(1, 1, T_NS, B_SINGLE, 1);
      tick();
      chk("l_grant", addr_sel, 2'b10);
      set_m(0, 1, T_NS, B_SINGLE, 0); #1;
      chk("l_stall0", hready_m, 2'b10);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("l_addr_held", addr_sel, 2'b10);
         chk("l_m0_stall", hready_m, 2'b10);
      end
      chk("l_data", data_sel, 2'b10);
      set_m(1, 1, T_NS, B_SINGLE, 0);
      tick();
      chk("l_release_addr", addr_sel, 2'b01);
      chk("l_release_owner", 2'(owner_idx), 2'b00);
      chk("l_release_data", data_sel, 2'b10);
      set_m(1, 0, T_IDLE, B_SINGLE, 0);
      tick();
      chk("l_m0_data", data_sel, 2'b01);
      set_m(0, 0, T_IDLE, B_SINGLE, 0);
      tick();
      chk("l_idle_addr", addr_sel, 2'b00);

      // continuous contention
`ifdef ARB_RR_EN
      exp_a = '{2'b10, 2'b01, 2'b10, 2'b01};
      exp_d = '{2'b00, 2'b10, 2'b01, 2'b10};
`else
      exp_a = '{2'b01, 2'b01, 2'b01, 2'b01};
      exp_d = '{2'b00, 2'b01, 2'b01, 2'b01};
`endif
      set_m(0, 1, T_NS, B_SINGLE, 0);
      set_m(1, 1, T_NS, B_SINGLE, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("c_addr", addr_sel, exp_a[i]);
         chk("c_data", data_sel, exp_d[i]);
      end
      set_m(0, 0, T_IDLE, B_SINGLE, 0);
      set_m(1, 0, T_IDLE, B_SINGLE, 0);
      tick();
      chk("c_idle_addr", addr_sel, 2'b00);

      // reset in the middle of an INCR8 burst
      set_m(0, 1, T_NS, B_INCR8, 0);
      tick();
      chk("r_grant", addr_sel, 2'b01);
      set_m(1, 1, T_NS, B_SINGLE, 0);
      tick();
      set_m(0, 1, T_SEQ, B_INCR8, 0);
      tick();
      chk("r_mid_addr", addr_sel, 2'b01);
      chk("r_mid_data", data_sel, 2'b01);
      chk("r_mid_hready", hready_m, 2'b01);
      hreset = 1'b1; #1;
      chk("r_async_addr", addr_sel, 2'b00);
      chk("r_async_data", data_sel, 2'b00);
      chk("r_async_owner", 2'(owner_idx), 2'b00);
      chk("r_async_hready", hready_m, 2'b11);
      hreq = '0; htrans = '0; hburst = '0; hmastlock = '0;
      tick();
      hreset = 1'b0;
      set_m(1, 1, T_NS, B_SINGLE, 0);
      tick();
      chk("r_after_addr", addr_sel, 2'b10);
      chk("r_after_owner", 2'(owner_idx), 2'b01);
      tick();
      chk("r_after_data", data_sel, 2'b10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
